reveal_sequencer: RTL
=====================

# reveal_sequencer

Sequences cell reveals for the 3x3 minesweeper board. The game FSM issues a one-cycle start with the confirmed cursor cell. This block walks the board one cell per clock and emits one-hot reveal strobes that the game ORs into its reveal grid. It flood-fills outward from zero-count cells and flags a bomb hit. It sits between the game control FSM and the reveal/bomb/adjacency-count datapath.

## Interface
- SIDE, 3, board side length; CELLS = SIDE*SIDE; cell i = row*SIDE+col, bit i of every grid
- CNT_W, 4, adjacency-count width per cell
- clock  in  1  single system clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  one-cycle request; accepted only in IDLE
- index  in  4  start cell, 0..CELLS-1
- abort  in  1  synchronous cancel (game restart)
- bombGrid  in  CELLS  1 = bomb in cell
- revealGrid  in  CELLS  current reveal grid from the game
- states  in  CNT_W*CELLS  adjacency counts; cell i at [CNT_W*i+CNT_W-1 : CNT_W*i]
- revealSet  out  CELLS  registered one-hot reveal strobe, one cycle per revealed cell
- hitBomb  out  1  registered pulse, coincident with the strobe of a bomb cell
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle completion pulse (state DONE)
- revealCount  out  4  cells revealed by the last request; held until the next accepted start

## Operation
- FSM states: IDLE, FILL, DONE. Internal regs: pending[CELLS], visited[CELLS], count.
- IDLE + start + !abort:
  - If index >= CELLS or revealGrid[index]=1 -> DONE; count <= 0.
  - Otherwise pending <= onehot(index); visited <= 0; count <= 0; go FILL.
- FILL, each edge:
  - Select p = lowest set bit of pending; clear it.
  - If revealGrid[p]=1, skip the cell: no strobe, no count change.
  - Otherwise revealSet <= onehot(p), visited[p] <= 1, count <= count+1.
  - If bombGrid[p]=1: hitBomb <= 1, pending <= 0, go DONE.
  - If states[p]==0: OR into pending every in-bounds 8-neighbour n with !bombGrid[n], !visited[n], !revealGrid[n], n != p.
  - If the updated pending is empty, go DONE.
- DONE: done=1 for one cycle, then IDLE.
- Each cell is strobed at most once per request. FILL lasts at most CELLS cycles. count never exceeds CELLS.
- abort in any state: next edge goes to IDLE. Clears pending and visited. No done is issued. revealSet and hitBomb go to 0. revealCount keeps its last value.
- Ties: abort beats start. start is ignored while busy.
- Inputs are sampled live each FILL cycle. Grid changes made by the game mid-fill take effect on the next processed cell.

## Timing
- Reset values: state=IDLE, revealSet=0, hitBomb=0, busy=0, done=0, revealCount=0, pending=0, visited=0.
- start sampled at edge 0 -> busy from cycle 1 -> first revealSet in cycle 2.
- The final strobe coincides with done: k processed cells gives done in cycle k+1.
- Rejected start (revealed or out-of-range cell): done in cycle 1, no strobe, revealCount=0.
- revealCount updates together with done.

## Configuration
- REVEAL_FLOOD_FILL_EN defined: neighbour expansion as above.
- REVEAL_FLOOD_FILL_EN undefined: no expansion. Only the start cell is processed; timing and bomb handling are unchanged; revealCount is at most 1.

## Test plan
- Reset asserted mid-FILL -> same cycle: revealSet=0, busy=0, done=0, revealCount=0, no further strobes.
- bombGrid=9'b000000001, states: cells 1,3,4 = 1, others 0; start index=8 -> revealSet order is cells 8,4,5,1,2,7,3,6 in cycles 2..9. done in cycle 9, revealCount=8, hitBomb never asserted.
- Same grids, start index=0 -> cycle 2: revealSet=9'b000000001, hitBomb=1, done=1, revealCount=1.
- revealGrid=9'b000010000, start index=4 -> done in cycle 1, no strobe, revealCount=0. Same result for index=9.
- Flood from the first scenario, abort at cycle 4 -> busy=0 from cycle 5, no done, no strobes after cycle 4. A start during cycles 2-3 is ignored.
- REVEAL_FLOOD_FILL_EN undefined, first scenario -> only revealSet=9'b100000000 in cycle 2, done in cycle 2, revealCount=1.

Source files
------------

// File: rtl/reveal_sequencer.sv
// reveal_sequencer: walks board cells one per clock, strobing reveals.
// Define REVEAL_FLOOD_FILL_EN to expand outward from zero-count cells.
module reveal_sequencer #(
  parameter int SIDE  = 3,
  parameter int CNT_W = 4,
  parameter int CELLS = SIDE * SIDE
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [3:0]             index,
  input  logic                   abort,
  input  logic [CELLS-1:0]       bombGrid,
  input  logic [CELLS-1:0]       revealGrid,
  input  logic [CNT_W*CELLS-1:0] states,
  output logic [CELLS-1:0]       revealSet,
  output logic                   hitBomb,
  output logic                   busy,
  output logic                   done,
  output logic [3:0]             revealCount
);

  localparam int IDX_W = $clog2(CELLS);
  localparam logic [3:0] CELLS_4 = 4'(CELLS);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DONE
  } state_t;

  state_t           state;
  logic [CELLS-1:0] pending;
  logic [CELLS-1:0] visited;
  logic [3:0]       count;

  logic [IDX_W-1:0] sel;
  logic [CELLS-1:0] sel_hot;
  logic [CELLS-1:0] start_hot;
  logic [CELLS-1:0] expand;
  logic [CELLS-1:0] pend_next;
  logic [3:0]       count_next;
  logic             cell_live;
  logic             cell_bomb;
  logic             zero_cnt;
  logic             start_bad;

  function automatic logic [CELLS-1:0] nbr_mask(input int p);
    int r;
    int c;
    nbr_mask = '0;
    r = p / SIDE;
    c = p % SIDE;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        if ((dr != 0 || dc != 0) &&
            r + dr >= 0 && r + dr < SIDE &&
            c + dc >= 0 && c + dc < SIDE)
          nbr_mask[(r + dr) * SIDE + c + dc] = 1'b1;
      end
    end
  endfunction

  // lowest pending cell is processed first
  always_comb begin
    sel = '0;
    for (int i = CELLS - 1; i >= 0; i--) begin
      if (pending[i])
        sel = IDX_W'(i);
    end
  end

  assign sel_hot   = CELLS'(1) << sel;
  assign start_hot = CELLS'(1) << index;
  assign start_bad = (index >= CELLS_4) || revealGrid[index];
  assign cell_live = (|pending) && !revealGrid[sel];
  assign cell_bomb = bombGrid[sel];
  assign zero_cnt  = states[CNT_W*sel +: CNT_W] == '0;

`ifdef REVEAL_FLOOD_FILL_EN
  always_comb begin
    expand = '0;
    if (cell_live && !cell_bomb && zero_cnt)
      expand = nbr_mask(int'(sel)) & ~bombGrid & ~visited
             & ~revealGrid & ~sel_hot;
  end
`else
  logic unused_flood;
  assign unused_flood = ^{zero_cnt, visited};
  assign expand = '0;
`endif

  assign pend_next = (cell_live && cell_bomb) ? '0
                   : (pending & ~sel_hot) | expand;
  assign count_next = count + 4'(cell_live);

  assign busy = state != IDLE;
  assign done = state == DONE;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      pending     <= '0;
      visited     <= '0;
      count       <= '0;
      revealSet   <= '0;
      hitBomb     <= 1'b0;
      revealCount <= '0;
    end else begin
      revealSet <= '0;
      hitBomb   <= 1'b0;
      if (abort) begin
        state   <= IDLE;
        pending <= '0;
        visited <= '0;
      end else begin
        unique case (1'b1)
          state == IDLE: begin
            if (start) begin
              count <= '0;
              if (start_bad) begin
                state       <= DONE;
                revealCount <= '0;
              end else begin
                state   <= FILL;
                pending <= start_hot;
                visited <= '0;
              end
            end
          end
          state == FILL: begin
            pending <= pend_next;
            if (cell_live) begin
              revealSet    <= sel_hot;
              visited[sel] <= 1'b1;
              count        <= count_next;
              hitBomb      <= cell_bomb;
            end
            if (pend_next == '0) begin
              state       <= DONE;
              revealCount <= count_next;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
